// File: rtl/rf_pkg.sv
// Shared constants and types for the register file and its scoreboard.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

  // Index of the register that can be hardwired to zero.
  localparam int RF_R0 = 0;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  // Register count implied by an address width.
  function automatic int rf_nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback side bus of the register file: read ports, write port,
// scoreboard reserve/flush and hazard status.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              rd_valid;
  logic              a_busy;
  logic              b_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              flush;
  logic [ADDR_W:0]   pend_cnt;

  // Pipeline side: drives requests, observes data and hazard status.
  modport master (
    output rd_en, a_addr, b_addr, wr_en, c_addr, c_data, rsv_en, rsv_addr, flush,
    input  a_data, b_data, rd_valid, a_busy, b_busy, pend_cnt
  );

  // Register file side.
  modport slave (
    input  rd_en, a_addr, b_addr, wr_en, c_addr, c_data, rsv_en, rsv_addr, flush,
    output a_data, b_data, rd_valid, a_busy, b_busy, pend_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when an instruction
// targeting it issues, cleared when its writeback lands or on a flush.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W  = RF_ADDR_W,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              a_busy,
  output logic              b_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = rf_nregs(ADDR_W);

  logic [NREGS-1:0] w_pending;
  logic [ADDR_W:0]  w_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_pend
      if (ZERO_R0 && gi == RF_R0) begin : g_zero
        assign w_pending[gi] = 1'b0;
      end else begin : g_bit
        logic r_pend;
        logic w_pend_next;

        // Flush beats reserve; reserve (younger instruction) beats release.
        always_comb begin
          w_pend_next = r_pend;
          if (flush) begin
            w_pend_next = 1'b0;
          end else if (rsv_en && rsv_addr == ADDR_W'(gi)) begin
            w_pend_next = 1'b1;
          end else if (wr_en && c_addr == ADDR_W'(gi)) begin
            w_pend_next = 1'b0;
          end
        end

        // Pending bit register.
        always_ff @(posedge clock or negedge clear_n) begin
          if (!clear_n) begin
            r_pend <= 1'b0;
          end else begin
            r_pend <= w_pend_next;
          end
        end

        assign w_pending[gi] = r_pend;
      end
    end
  endgenerate

  // Population count of outstanding writes.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_cnt = w_cnt + {{ADDR_W{1'b0}}, w_pending[i]};
    end
  end

  assign pend_cnt = w_cnt;

  // A writeback landing this cycle resolves the hazard when it is forwarded.
  assign a_busy = w_pending[a_addr] & ~(BYPASS & wr_en & (c_addr == a_addr));
  assign b_busy = w_pending[b_addr] & ~(BYPASS & wr_en & (c_addr == b_addr));

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with registered reads, write-to-read
// forwarding, optional zero R0 and a pending-write scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input logic          clock,
  input logic          clear_n,
  reg_file_sb_if.slave bus
);

  localparam int NREGS = rf_nregs(ADDR_W);

  logic [DATA_W-1:0] w_mem [NREGS];
  logic              r_rd_valid;
  logic              w_a_busy;
  logic              w_b_busy;
  logic [ADDR_W:0]   w_pend_cnt;

  genvar gi;
  generate
    // Storage: every register is a resettable flop so clear_n zeroes the file.
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (ZERO_R0 && gi == RF_R0) begin : g_zero
        assign w_mem[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] r_q;

        // Writeback into this register.
        always_ff @(posedge clock or negedge clear_n) begin
          if (!clear_n) begin
            r_q <= '0;
          end else if (bus.wr_en && bus.c_addr == ADDR_W'(gi)) begin
            r_q <= bus.c_data;
          end
        end

        assign w_mem[gi] = r_q;
      end
    end

    // Read ports: index 0 is port A, index 1 is port B.
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_next;
      logic [DATA_W-1:0] r_data;

      assign w_addr = (gi == 0) ? bus.a_addr : bus.b_addr;

      // Read mux: zero R0 first, then forwarded write data, then the array.
      always_comb begin
        w_next = w_mem[w_addr];
        if (ZERO_R0 && w_addr == ADDR_W'(RF_R0)) begin
          w_next = '0;
        end else if (BYPASS && bus.wr_en && bus.c_addr == w_addr) begin
          w_next = bus.c_data;
        end
      end

      // Output register, loaded only on rd_en so data holds between reads.
      always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
          r_data <= '0;
        end else if (bus.rd_en) begin
          r_data <= w_next;
        end
      end
    end
  endgenerate

  // Marks that a_data/b_data were refreshed on the last edge.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clock    (clock),
    .clear_n  (clear_n),
    .wr_en    (bus.wr_en),
    .c_addr   (bus.c_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .flush    (bus.flush),
    .a_addr   (bus.a_addr),
    .b_addr   (bus.b_addr),
    .a_busy   (w_a_busy),
    .b_busy   (w_b_busy),
    .pend_cnt (w_pend_cnt)
  );

  assign bus.a_data   = g_rd[0].r_data;
  assign bus.b_data   = g_rd[1].r_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.a_busy   = w_a_busy;
  assign bus.b_busy   = w_b_busy;
  assign bus.pend_cnt = w_pend_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (zero-R0 + bypass, and plain) share
// one stimulus stream and are checked against an array/bitmap model.
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam int DW = RF_DATA_W;
  localparam int AW = RF_ADDR_W;
  localparam int NR = 1 << AW;

  logic clock = 1'b0;
  logic clear_n;

  always #5 clock = ~clock;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus1.rd_en    = bus0.rd_en;
  assign bus1.a_addr   = bus0.a_addr;
  assign bus1.b_addr   = bus0.b_addr;
  assign bus1.wr_en    = bus0.wr_en;
  assign bus1.c_addr   = bus0.c_addr;
  assign bus1.c_data   = bus0.c_data;
  assign bus1.rsv_en   = bus0.rsv_en;
  assign bus1.rsv_addr = bus0.rsv_addr;
  assign bus1.flush    = bus0.flush;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut0 (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus0)
  );

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut1 (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus1)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit checking = 1'b0;

  // Reference model, one slot per instance.
  bit       m_z  [2] = '{1'b1, 1'b0};
  bit       m_by [2] = '{1'b1, 1'b0};
  rf_data_t m_mem  [2][NR];
  bit       m_pend [2][NR];
  rf_data_t m_a [2];
  rf_data_t m_b [2];
  bit       m_v [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic rf_data_t model_read(input int d, input rf_addr_t addr);
    if (m_z[d] && addr == 0) return '0;
    if (m_by[d] && bus0.wr_en && bus0.c_addr == addr) return bus0.c_data;
    return m_mem[d][addr];
  endfunction

  function automatic bit exp_busy(input int d, input rf_addr_t addr);
    return m_pend[d][addr] && !(m_by[d] && bus0.wr_en && bus0.c_addr == addr);
  endfunction

  function automatic int exp_cnt(input int d);
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_pend[d][i]);
    return n;
  endfunction

  // Model update on each clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clock or negedge clear_n);
      if (!clear_n) begin
        for (int d = 0; d < 2; d++) begin
          for (int i = 0; i < NR; i++) begin
            m_mem[d][i]  = '0;
            m_pend[d][i] = 1'b0;
          end
          m_a[d] = '0;
          m_b[d] = '0;
          m_v[d] = 1'b0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (bus0.rd_en) begin
            m_a[d] = model_read(d, bus0.a_addr);
            m_b[d] = model_read(d, bus0.b_addr);
          end
          m_v[d] = bus0.rd_en;
          if (bus0.wr_en && !(m_z[d] && bus0.c_addr == 0)) m_mem[d][bus0.c_addr] = bus0.c_data;
          if (bus0.flush) begin
            for (int i = 0; i < NR; i++) m_pend[d][i] = 1'b0;
          end else begin
            if (bus0.wr_en)  m_pend[d][bus0.c_addr]   = 1'b0;
            if (bus0.rsv_en) m_pend[d][bus0.rsv_addr] = 1'b1;
          end
          if (m_z[d]) m_pend[d][0] = 1'b0;
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input logic [DW-1:0] ad, input logic [DW-1:0] bd,
                         input logic v, input logic ab, input logic bb, input logic [AW:0] pc);
    chk($sformatf("d%0d_a_data", d),   32'(ad), 32'(m_a[d]));
    chk($sformatf("d%0d_b_data", d),   32'(bd), 32'(m_b[d]));
    chk($sformatf("d%0d_rd_valid", d), 32'(v),  32'(m_v[d]));
    chk($sformatf("d%0d_a_busy", d),   32'(ab), 32'(exp_busy(d, bus0.a_addr)));
    chk($sformatf("d%0d_b_busy", d),   32'(bb), 32'(exp_busy(d, bus0.b_addr)));
    chk($sformatf("d%0d_pend_cnt", d), 32'(pc), 32'(exp_cnt(d)));
  endtask

  // Compare both instances against the model every cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (checking) begin
        cmp_dut(0, bus0.a_data, bus0.b_data, bus0.rd_valid, bus0.a_busy, bus0.b_busy, bus0.pend_cnt);
        cmp_dut(1, bus1.a_data, bus1.b_data, bus1.rd_valid, bus1.a_busy, bus1.b_busy, bus1.pend_cnt);
      end
    end
  end

  task automatic idle();
    bus0.rd_en    = 1'b0;
    bus0.a_addr   = '0;
    bus0.b_addr   = '0;
    bus0.wr_en    = 1'b0;
    bus0.c_addr   = '0;
    bus0.c_data   = '0;
    bus0.rsv_en   = 1'b0;
    bus0.rsv_addr = '0;
    bus0.flush    = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_n = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    clear_n  = 1'b1;
    checking = 1'b1;

    // Reset values.
    bus0.rd_en = 1'b1; bus0.a_addr = 4'd3; bus0.b_addr = 4'd10;
    step();
    chk("rst_a_data", 32'(bus0.a_data), 32'h0);
    chk("rst_b_data", 32'(bus0.b_data), 32'h0);
    chk("rst_rd_valid", 32'(bus0.rd_valid), 32'h1);
    chk("rst_pend_cnt", 32'(bus0.pend_cnt), 32'h0);

    // Write then read.
    idle(); bus0.wr_en = 1'b1; bus0.c_addr = 4'd11; bus0.c_data = 16'h7694;
    step();
    idle(); bus0.rd_en = 1'b1; bus0.a_addr = 4'd11;
    step();
    chk("wr_rd_d0", 32'(bus0.a_data), 32'h7694);
    chk("wr_rd_d1", 32'(bus1.a_data), 32'h7694);
    chk("model_wr_rd", 32'(m_a[0]), 32'h7694);

    // Same-cycle forwarding vs. old value.
    idle(); bus0.wr_en = 1'b1; bus0.c_addr = 4'd5; bus0.c_data = 16'hBEEF;
    bus0.rd_en = 1'b1; bus0.a_addr = 4'd5; bus0.b_addr = 4'd11;
    step();
    chk("bypass_d0", 32'(bus0.a_data), 32'hBEEF);
    chk("nobypass_d1", 32'(bus1.a_data), 32'h0);
    chk("bypass_b_d0", 32'(bus0.b_data), 32'h7694);

    // Hardwired R0.
    idle(); bus0.wr_en = 1'b1; bus0.c_addr = 4'd0; bus0.c_data = 16'hFFFF;
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 4'd0;
    step();
    idle(); bus0.rd_en = 1'b1; bus0.a_addr = 4'd0;
    #1;
    chk("r0_busy_d0", 32'(bus0.a_busy), 32'h0);
    chk("r0_pend_d0", 32'(bus0.pend_cnt), 32'h0);
    chk("r0_busy_d1", 32'(bus1.a_busy), 32'h1);
    chk("r0_pend_d1", 32'(bus1.pend_cnt), 32'h1);
    step();
    chk("r0_data_d0", 32'(bus0.a_data), 32'h0);
    chk("r0_data_d1", 32'(bus1.a_data), 32'hFFFF);
    idle(); bus0.flush = 1'b1;
    step();
    idle();
    #1;
    chk("flush_d1", 32'(bus1.pend_cnt), 32'h0);

    // Scoreboard reserve / release.
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 4'd2;
    step();
    idle(); bus0.a_addr = 4'd2;
    #1;
    chk("sb_busy", 32'(bus0.a_busy), 32'h1);
    chk("sb_cnt1", 32'(bus0.pend_cnt), 32'h1);
    bus0.wr_en = 1'b1; bus0.c_addr = 4'd2; bus0.c_data = 16'h1234;
    #1;
    chk("sb_busy_byp_d0", 32'(bus0.a_busy), 32'h0);
    chk("sb_busy_nobyp_d1", 32'(bus1.a_busy), 32'h1);
    step();
    chk("sb_release_cnt", 32'(bus0.pend_cnt), 32'h0);
    idle(); bus0.rsv_en = 1'b1; bus0.rsv_addr = 4'd2;
    bus0.wr_en = 1'b1; bus0.c_addr = 4'd2; bus0.c_data = 16'h55AA;
    step();
    idle(); bus0.a_addr = 4'd2;
    #1;
    chk("sb_rsv_wins_cnt", 32'(bus0.pend_cnt), 32'h1);
    chk("sb_rsv_wins_busy", 32'(bus0.a_busy), 32'h1);

    // Flush overrides a concurrent reserve.
    idle(); bus0.flush = 1'b1;
    step();
    idle(); bus0.rsv_en = 1'b1; bus0.rsv_addr = 4'd1; step();
    bus0.rsv_addr = 4'd4; step();
    bus0.rsv_addr = 4'd7; step();
    idle();
    #1;
    chk("fl_cnt3", 32'(bus0.pend_cnt), 32'h3);
    bus0.flush = 1'b1; bus0.rsv_en = 1'b1; bus0.rsv_addr = 4'd9;
    step();
    idle(); bus0.a_addr = 4'd9;
    #1;
    chk("fl_cnt0_d0", 32'(bus0.pend_cnt), 32'h0);
    chk("fl_busy9", 32'(bus0.a_busy), 32'h0);
    chk("fl_cnt0_d1", 32'(bus1.pend_cnt), 32'h0);

    // Asynchronous reset mid-cycle.
    bus0.wr_en = 1'b1; bus0.c_addr = 4'd6; bus0.c_data = 16'hA5C3;
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 4'd3;
    step();
    idle(); bus0.rd_en = 1'b1; bus0.a_addr = 4'd6;
    step();
    chk("ar_pre_data", 32'(bus0.a_data), 32'hA5C3);
    idle();
    #3;
    clear_n = 1'b0;
    #1;
    chk("ar_a_data_d0", 32'(bus0.a_data), 32'h0);
    chk("ar_rd_valid", 32'(bus0.rd_valid), 32'h0);
    chk("ar_pend_cnt", 32'(bus0.pend_cnt), 32'h0);
    chk("ar_a_data_d1", 32'(bus1.a_data), 32'h0);
    @(posedge clock);
    #1;
    clear_n = 1'b1;
    bus0.rd_en = 1'b1; bus0.a_addr = 4'd6; bus0.b_addr = 4'd11;
    step();
    chk("ar_cleared_a", 32'(bus0.a_data), 32'h0);
    chk("ar_cleared_b", 32'(bus1.b_data), 32'h0);

    // Randomized traffic, biased toward address collisions.
    for (int n = 0; n < 2000; n++) begin
      bus0.rd_en    = ($urandom_range(0, 3) != 0);
      bus0.a_addr   = ($urandom_range(0, 7) == 0) ? rf_addr_t'(0) : rf_addr_t'($urandom_range(0, NR - 1));
      bus0.b_addr   = rf_addr_t'($urandom_range(0, NR - 1));
      bus0.wr_en    = ($urandom_range(0, 1) != 0);
      bus0.c_addr   = ($urandom_range(0, 3) == 0) ? bus0.a_addr : rf_addr_t'($urandom_range(0, NR - 1));
      bus0.c_data   = rf_data_t'($urandom);
      bus0.rsv_en   = ($urandom_range(0, 1) != 0);
      bus0.rsv_addr = ($urandom_range(0, 3) == 0) ? bus0.c_addr : rf_addr_t'($urandom_range(0, NR - 1));
      bus0.flush    = ($urandom_range(0, 15) == 0);
      step();
    end

    idle();
    step();
    step();
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file for the pipelined RISC core. It provides two registered read ports and one write port. It adds write-to-read bypass, an optional hardwired-zero R0, and a per-register scoreboard of pending writes. Decode uses the scoreboard to detect RAW hazards and stall. It sits between decode (read and reserve) and writeback (write and release).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; NREGS = 2**ADDR_W registers (derived, not overridable)
ZERO_R0, 1, 1: R0 always reads 0, writes and reservations to R0 ignored
BYPASS, 1, 1: a same-cycle write to the read address forwards c_data to the read port

Ports:
clock  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
rd_en  in  1  capture reads this cycle
a_addr  in  ADDR_W  read port A address
b_addr  in  ADDR_W  read port B address
a_data  out  DATA_W  registered read data A
b_data  out  DATA_W  registered read data B
rd_valid  out  1  a_data/b_data updated on last edge
a_busy  out  1  comb: a_addr has an unresolved pending write
b_busy  out  1  comb: b_addr has an unresolved pending write
wr_en  in  1  writeback strobe
c_addr  in  ADDR_W  write address
c_data  in  DATA_W  write data
rsv_en  in  1  reserve rsv_addr (instruction issued with this destination)
rsv_addr  in  ADDR_W  destination being reserved
flush  in  1  clear all pending bits (pipeline flush)
pend_cnt  out  ADDR_W+1  comb popcount of the pending bits

Behaviour:
- Reset: one clock; reset asynchronous, active-low (clock, clear_n). While clear_n=0:
  - all registers = 0; pending = 0
  - a_data = b_data = 0; rd_valid = 0
  - takes effect immediately, including mid-operation; no edge is needed
- Write: on posedge with wr_en=1, reg[c_addr] <= c_data. Ignored when ZERO_R0=1 and c_addr=0.
- Read latency is 1 cycle. On posedge with rd_en=1, a_data takes the first matching case:
  - 0 if ZERO_R0=1 and a_addr=0
  - else c_data if BYPASS=1 and wr_en=1 and c_addr=a_addr
  - else the old reg[a_addr]
  - b_data follows the same rules using b_addr.
- With BYPASS=0, a same-cycle read of the write address returns the old value.
- With rd_en=0, a_data and b_data hold.
- rd_valid <= rd_en every edge.
- Scoreboard, per-register bit pending[i], updated on posedge:
  - Release: wr_en=1 clears pending[c_addr].
  - Reserve: rsv_en=1 sets pending[rsv_addr]; reserve wins over release when rsv_addr=c_addr in the same cycle (younger instruction).
  - Reserving an already-pending register leaves it set.
  - Flush: flush=1 clears all bits and overrides rsv_en in the same cycle. A concurrent write to the array still occurs.
  - With ZERO_R0=1, pending[0] is constantly 0.
- a_busy = pending[a_addr] AND NOT (BYPASS and wr_en and c_addr=a_addr). Same rule for b_busy.
- No internal stall: reads issued while busy return current contents; the caller must not assert rd_en while busy.
- Widths: no arithmetic on data. pend_cnt ranges 0..NREGS and needs ADDR_W+1 bits.

Decomposition:
- Package rf_pkg:
  - RF_DATA_W=16, RF_ADDR_W=4 defaults
  - R0 address constant
  - rf_addr_t / rf_data_t typedefs
- Sub-module rf_scoreboard: pending vector, reserve/release/flush priority, popcount, busy lookups.
- Array, read registers and bypass mux stay in reg_file_sb.

Test Plan:
- Reset values -> after clear_n=0 then 1, rd_en with a_addr=3, b_addr=10 -> next edge a_data=0, b_data=0, rd_valid=1, pend_cnt=0.
- Write then read -> wr_en, c_addr=11, c_data=16'h7694; next cycle rd_en, a_addr=11 -> a_data=16'h7694.
- Bypass -> same cycle: wr_en c_addr=5 c_data=16'hBEEF, rd_en a_addr=5 -> a_data=16'hBEEF; repeat with BYPASS=0 -> old value 0.
- R0 hardwired -> wr_en c_addr=0 c_data=16'hFFFF, rsv_en rsv_addr=0; then read a_addr=0 -> a_data=0, a_busy=0, pend_cnt=0.
- Scoreboard:
  - rsv_en rsv_addr=2 -> a_busy=1 for a_addr=2, pend_cnt=1.
  - Later wr_en c_addr=2 -> a_busy=0 in that cycle (bypass), pend_cnt=0 after the edge.
  - Same-cycle rsv_en and wr_en on 2 -> pending stays 1.
- Flush and async reset:
  - Reserve 1, 4, 7 -> pend_cnt=3; flush with rsv_en rsv_addr=9 -> pend_cnt=0 after the edge.
  - Drop clear_n mid-cycle with data present -> a_data=0 and pending=0 before the next clock edge.
